// File: rtl/fwd_hazard_tracker.sv
// Purpose: ID-stage forwarding selects and load-use stall from a self-owned destination-register history (optional stats: FWD_HAZARD_STATS_EN).
// Latency: selects and stall are combinational (zero cycles) from the registered tracker and current id_* inputs.
// Backpressure: stall_in freezes the tracker; stall_id inserts a bubble until the load reaches stage LOAD_RDY.
module fwd_hazard_tracker #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    input  logic              stall_in,
`ifdef FWD_HAZARD_STATS_EN
    output logic [31:0]       stat_stall,
    output logic [31:0]       stat_fwd,
`endif
    output logic [SEL_W-1:0]  hd_rs,
    output logic [SEL_W-1:0]  hd_rt,
    output logic              stall_id
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } trk_ent_t;

    trk_ent_t          trk_q [DEPTH];
    trk_ent_t          new_ent;
    logic [SEL_W-1:0]  rs_sel;
    logic [SEL_W-1:0]  rt_sel;
    logic              rs_haz;
    logic              rt_haz;

    // Walk from the oldest stage to the newest so the nearest match is the last one kept;
    // the hazard flag follows only that winner, so an older ready entry cannot mask it.
    always_comb begin
        rs_sel = '0;
        rt_sel = '0;
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (trk_q[k].vld && (trk_q[k].rd == id_rs) && (id_rs != '0)) begin
                rs_sel = SEL_W'(k + 1);
                rs_haz = trk_q[k].ld && (k < LOAD_RDY);
            end
            if (trk_q[k].vld && (trk_q[k].rd == id_rt) && (id_rt != '0)) begin
                rt_sel = SEL_W'(k + 1);
                rt_haz = trk_q[k].ld && (k < LOAD_RDY);
            end
        end
    end

    assign hd_rs    = rst ? '0 : rs_sel;
    assign hd_rt    = rst ? '0 : rt_sel;
    assign stall_id = !rst && id_valid && !flush && (rs_haz || rt_haz);

    always_comb begin
        new_ent     = '0;
        new_ent.vld = id_valid && id_regwrite && (id_rd != '0) && !flush && !stall_id;
        new_ent.rd  = new_ent.vld ? id_rd : '0;
        new_ent.ld  = new_ent.vld && id_memread;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                trk_q[k] <= '0;
            end
        end else if (!stall_in) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                trk_q[k] <= trk_q[k-1];
            end
            trk_q[0] <= new_ent;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic fwd_evt;

    assign fwd_evt = id_valid && !stall_id && !stall_in && ((hd_rs != '0) || (hd_rt != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall <= '0;
            stat_fwd   <= '0;
        end else begin
            if (stall_id && !stall_in) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (fwd_evt) begin
                stat_fwd <= stat_fwd + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Table-driven bench for fwd_hazard_tracker (default LOAD_RDY=1) plus a LOAD_RDY=2 instance and stats sequence.
module tb_fwd_hazard_tracker;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic       stall_in;
    logic [1:0] hd_rs;
    logic [1:0] hd_rt;
    logic       stall_id;
    logic [1:0] hd_rs2;
    logic [1:0] hd_rt2;
    logic       stall_id2;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stat_stall;
    logic [31:0] stat_fwd;
    logic [31:0] stat_stall2;
    logic [31:0] stat_fwd2;
`endif

    int checks = 0;
    int errors = 0;

    fwd_hazard_tracker #(.REG_AW(5), .DEPTH(3), .LOAD_RDY(1)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall_in(stall_in),
`ifdef FWD_HAZARD_STATS_EN
        .stat_stall(stat_stall), .stat_fwd(stat_fwd),
`endif
        .hd_rs(hd_rs), .hd_rt(hd_rt), .stall_id(stall_id)
    );

    fwd_hazard_tracker #(.REG_AW(5), .DEPTH(3), .LOAD_RDY(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall_in(stall_in),
`ifdef FWD_HAZARD_STATS_EN
        .stat_stall(stat_stall2), .stat_fwd(stat_fwd2),
`endif
        .hd_rs(hd_rs2), .hd_rt(hd_rt2), .stall_id(stall_id2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       si;
        logic [1:0] e_rs;
        logic [1:0] e_rt;
        logic       e_st;
    } vec_t;

    localparam int NVEC = 29;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input int r, input int v, input int rs, input int rt, input int rd,
                                input int rw, input int mr, input int fl, input int si,
                                input int ers, input int ert, input int est);
        vec_t t;
        t.rst = r[0];   t.v = v[0];     t.rs = rs[4:0]; t.rt = rt[4:0]; t.rd = rd[4:0];
        t.rw = rw[0];   t.mr = mr[0];   t.fl = fl[0];   t.si = si[0];
        t.e_rs = ers[1:0]; t.e_rt = ert[1:0]; t.e_st = est[0];
        return t;
    endfunction

    task automatic apply(input vec_t t);
        rst = t.rst; id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_rd = t.rd;
        id_regwrite = t.rw; id_memread = t.mr; flush = t.fl; stall_in = t.si;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst v rs rt rd rw mr fl si   hd_rs hd_rt stall
        tbl[0]  = mk(1, 0, 3, 3, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 3, 1, 0, 0, 0,   0, 0, 0);
        tbl[2]  = mk(0, 1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0);
        tbl[3]  = mk(0, 1, 0, 3, 0, 0, 0, 0, 0,   0, 2, 0);
        tbl[4]  = mk(0, 1, 0, 3, 0, 0, 0, 0, 0,   0, 3, 0);
        tbl[5]  = mk(0, 1, 0, 3, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 5, 1, 1, 0, 0,   0, 0, 0);
        tbl[7]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 0,   1, 0, 1);
        tbl[8]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 0,   2, 0, 0);
        tbl[9]  = mk(0, 1, 5, 0, 7, 1, 0, 0, 0,   3, 0, 0);
        tbl[10] = mk(0, 1, 7, 0, 7, 1, 0, 0, 0,   1, 0, 0);
        tbl[11] = mk(0, 1, 7, 7, 0, 1, 0, 0, 0,   1, 1, 0);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[13] = mk(0, 1, 0, 7, 4, 1, 1, 0, 0,   0, 3, 0);
        tbl[14] = mk(0, 1, 4, 0, 0, 0, 0, 0, 1,   1, 0, 1);
        tbl[15] = mk(0, 1, 4, 0, 0, 0, 0, 0, 1,   1, 0, 1);
        tbl[16] = mk(0, 1, 4, 0, 0, 0, 0, 0, 1,   1, 0, 1);
        tbl[17] = mk(0, 1, 4, 0, 0, 0, 0, 0, 0,   1, 0, 1);
        tbl[18] = mk(0, 1, 4, 0, 0, 0, 0, 0, 0,   2, 0, 0);
        tbl[19] = mk(0, 1, 0, 0, 6, 1, 1, 0, 0,   0, 0, 0);
        tbl[20] = mk(0, 1, 6, 0, 9, 1, 0, 1, 0,   1, 0, 0);
        tbl[21] = mk(0, 1, 9, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[22] = mk(0, 1, 6, 0, 1, 1, 0, 0, 0,   3, 0, 0);
        tbl[23] = mk(0, 1, 1, 0, 2, 1, 0, 0, 0,   1, 0, 0);
        tbl[24] = mk(0, 1, 2, 1, 3, 1, 0, 0, 0,   1, 2, 0);
        tbl[25] = mk(1, 1, 3, 1, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[26] = mk(0, 1, 3, 2, 0, 0, 0, 0, 0,   0, 0, 0);
        tbl[27] = mk(0, 1, 0, 0, 8, 1, 1, 0, 0,   0, 0, 0);
        tbl[28] = mk(0, 0, 8, 0, 0, 0, 0, 0, 0,   1, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d hd_rs", i), hd_rs, tbl[i].e_rs);
            chk($sformatf("vec%0d hd_rt", i), hd_rt, tbl[i].e_rt);
            chk($sformatf("vec%0d stall_id", i), stall_id, tbl[i].e_st);
            next_cycle();
        end

        // LOAD_RDY=2 load-use: two stall cycles, then forward from stage 2
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        apply(mk(0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("lr2 lw stall", stall_id2, 0);
        next_cycle();
        apply(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("lr2 c1 hd_rs", hd_rs2, 1);
        chk("lr2 c1 stall", stall_id2, 1);
        chk("lr1 c1 stall", stall_id, 1);
        next_cycle();
        @(negedge clk);
        chk("lr2 c2 hd_rs", hd_rs2, 2);
        chk("lr2 c2 stall", stall_id2, 1);
        chk("lr1 c2 hd_rs", hd_rs, 2);
        chk("lr1 c2 stall", stall_id, 0);
        next_cycle();
        @(negedge clk);
        chk("lr2 c3 hd_rs", hd_rs2, 3);
        chk("lr2 c3 stall", stall_id2, 0);
`ifdef FWD_HAZARD_STATS_EN
        chk("stat_stall lr1", stat_stall, 1);
        chk("stat_fwd lr1", stat_fwd, 1);
        chk("stat_stall lr2", stat_stall2, 2);
        chk("stat_fwd lr2", stat_fwd2, 0);
`endif
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst hd_rs", hd_rs, 0);
        chk("rst stall lr2", stall_id2, 0);
`ifdef FWD_HAZARD_STATS_EN
        chk("rst stat_stall", stat_stall, 0);
        chk("rst stat_fwd", stat_fwd, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
